vanity_result_queue: RTL
========================

Name: vanity_result_queue

Overview:
- Downstream of the key adder, address hasher and vanity comparator.
- Tags each generated public key with its 64-bit iteration count.
- Carries that tag alongside the in-flight hash, so a comparator hit is attributed to the exact key that produced it.
- Buffers matched {cnt, hash} pairs in a small first-word-fall-through FIFO that the host drains through the virtual-wire readout.

Parameters:
- DEPTH, 8, result FIFO entries; power of 2, ≥2.
- TAG_DEPTH, 4, tag FIFO entries (keys in flight between adder and hasher); power of 2, ≥2.
- CNT_WIDTH, 64, iteration counter width.
- HASH_WIDTH, 160, address hash width.

Ports:
- mining_clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx_key_valid  in  1  1-cycle pulse: adder produced a key.
- rx_key_cnt  in  CNT_WIDTH  iteration count of that key.
- rx_hash_valid  in  1  1-cycle pulse: hasher finished the oldest key.
- rx_hash  in  HASH_WIDTH  hash, valid with rx_hash_valid.
- rx_cmp_valid  in  1  1-cycle pulse: comparator result for the pending hash.
- rx_cmp_match  in  1  1 = hash inside [min,max]; valid with rx_cmp_valid.
- rd_en  in  1  host pops result head.
- tx_empty  out  1  result FIFO empty.
- tx_count  out  log2(DEPTH)+1  result entries held.
- tx_cnt  out  CNT_WIDTH  head entry count (FWFT).
- tx_hash  out  HASH_WIDTH  head entry hash (FWFT).
- tx_overflow  out  16  dropped-match counter, saturating.
- tx_tag_error  out  1  sticky pipeline-misalignment flag.

Behaviour:
- Reset (reset=1 at a clock edge):
  - All state cleared; reset wins over every other input that cycle.
  - tx_empty=1, tx_count=0, tx_cnt=0, tx_hash=0, tx_overflow=0, tx_tag_error=0.
  - Pending register invalid; tag FIFO empty.
  - Entries in flight are discarded.
- Tag FIFO (TAG_DEPTH x CNT_WIDTH):
  - rx_key_valid pushes rx_key_cnt.
  - rx_hash_valid pops the head into the pending register, together with rx_hash, and sets pend_valid.
  - Push with the tag FIFO full and no simultaneous pop: key dropped, tx_tag_error<=1.
  - Push and pop in the same cycle when full: both succeed, no error.
  - Pop with the tag FIFO empty (including a same-cycle push into an empty FIFO; no bypass):
    - pending loaded with cnt = all-ones and rx_hash;
    - tx_tag_error<=1;
    - any simultaneous push still succeeds.
- Pending register / comparator stage:
  - rx_cmp_valid consumes pending: pend_valid<=0.
  - If rx_cmp_match=1 and pend_valid=1, {pend_cnt, pend_hash} is pushed into the result FIFO.
  - rx_cmp_valid with pend_valid=0: ignored, tx_tag_error<=1.
  - rx_hash_valid while pend_valid=1 and no rx_cmp_valid that cycle: old pending overwritten, tx_tag_error<=1.
  - rx_cmp_valid and rx_hash_valid in the same cycle: the compare uses the old pending, then the new hash loads; no error.
- Result FIFO (DEPTH x (CNT_WIDTH+HASH_WIDTH), FWFT):
  - Push at cycle N → tx_empty=0 and head visible at N+1 (1-cycle latency).
  - rd_en with tx_empty=0 advances the head; the next entry is visible the following cycle.
  - rd_en while empty: ignored; no underflow, count stays 0.
  - Push when full without rd_en: entry dropped, tx_overflow+1, saturating at 16'hFFFF.
  - Push with rd_en when full: both succeed, tx_count stays DEPTH.
  - Pointers wrap modulo DEPTH; tx_count ranges 0..DEPTH.
  - tx_cnt/tx_hash hold the last value when empty.
- tx_tag_error: sticky; cleared only by reset.
- No combinational path from any input to any output; all outputs registered.

Test Plan:
- Single-match alignment:
  - Stimulus: keys cnt=5,6,7; hash_valid x3 (hashes H5,H6,H7); cmp_valid with match only on the second.
  - Required: one entry {6,H6}, tx_count=1, tx_tag_error=0.
  - Then rd_en → tx_empty=1 the next cycle.
- Result overflow:
  - Stimulus: DEPTH+3 = 11 matches (cnt=0..10) with no reads.
  - Required: tx_count=8, tx_overflow=3; reading out yields cnt 0..7 in order.
  - Full + simultaneous push/rd: the new entry is retained and count stays 8.
- Tag misalignment:
  - Stimulus: hash_valid with the tag FIFO empty.
  - Required: tx_tag_error=1; a subsequent match pushes cnt=64'hFFFF_FFFF_FFFF_FFFF.
  - Stimulus: 5 keys with no hashes (TAG_DEPTH=4) → tx_tag_error=1.
- Same-cycle cmp_valid+hash_valid:
  - Stimulus: pending {3,H3}; cmp match and hash H4 arrive in one cycle, tag head=4.
  - Required: pushes {3,H3}; pending becomes {4,H4}; no error.
- Pointer wrap:
  - Stimulus: 20 matches with interleaved reads, keeping count ≤3.
  - Required: entries read out in order cnt=0..19; tx_overflow=0.
- Reset mid-operation:
  - Stimulus: reset with 5 results and 2 tags queued.
  - Required next cycle: tx_empty=1, tx_count=0, tx_overflow=0, tx_tag_error=0; the next key/hash/match sequence is tagged correctly.

Source files
------------

// File: rtl/vanity_result_queue_if.sv
// Bundle of the comparator-side inputs and host readout outputs of the vanity result queue.
// The slave modport is the queue itself; the master modport is the pipeline/host side driving it.
interface vanity_result_queue_if #(
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 64,
  parameter int HASH_WIDTH = 160
);
  logic                       rx_key_valid;
  logic [CNT_WIDTH-1:0]       rx_key_cnt;
  logic                       rx_hash_valid;
  logic [HASH_WIDTH-1:0]      rx_hash;
  logic                       rx_cmp_valid;
  logic                       rx_cmp_match;
  logic                       rd_en;
  logic                       tx_empty;
  logic [$clog2(DEPTH):0]     tx_count;
  logic [CNT_WIDTH-1:0]       tx_cnt;
  logic [HASH_WIDTH-1:0]      tx_hash;
  logic [15:0]                tx_overflow;
  logic                       tx_tag_error;

  modport slave (
    input  rx_key_valid, rx_key_cnt, rx_hash_valid, rx_hash,
           rx_cmp_valid, rx_cmp_match, rd_en,
    output tx_empty, tx_count, tx_cnt, tx_hash, tx_overflow, tx_tag_error
  );

  modport master (
    output rx_key_valid, rx_key_cnt, rx_hash_valid, rx_hash,
           rx_cmp_valid, rx_cmp_match, rd_en,
    input  tx_empty, tx_count, tx_cnt, tx_hash, tx_overflow, tx_tag_error
  );
endinterface

// File: rtl/vanity_result_queue.sv
// Tags each key with its iteration count, carries the tag past the hasher, and queues
// comparator hits as {cnt, hash} in a registered-output first-word-fall-through FIFO.
module vanity_result_queue #(
  parameter int DEPTH      = 8,
  parameter int TAG_DEPTH  = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int HASH_WIDTH = 160
) (
  input  logic                   mining_clk,
  input  logic                   reset,
  vanity_result_queue_if.slave   bus
);

  localparam int RPW = $clog2(DEPTH);
  localparam int RCW = RPW + 1;
  localparam int TPW = $clog2(TAG_DEPTH);
  localparam int TCW = TPW + 1;

  localparam logic [RCW-1:0] RES_FULL = RCW'(DEPTH);
  localparam logic [TCW-1:0] TAG_FULL = TCW'(TAG_DEPTH);

  typedef struct packed {
    logic [CNT_WIDTH-1:0]  cnt;
    logic [HASH_WIDTH-1:0] hash;
  } entry_t;

  // Tag FIFO
  logic [CNT_WIDTH-1:0] tag_mem [TAG_DEPTH];
  logic [TPW-1:0]       tag_wr_ptr;
  logic [TPW-1:0]       tag_rd_ptr;
  logic [TCW-1:0]       tag_count;
  logic                 tag_empty;
  logic                 tag_full;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 tag_err_set;

  // Pending (hashed, awaiting comparator) stage
  logic                 pend_valid;
  entry_t               pend;

  // Result FIFO
  entry_t               res_mem [DEPTH];
  logic [RPW-1:0]       res_wr_ptr;
  logic [RPW-1:0]       res_rd_ptr;
  logic [RCW-1:0]       res_count;
  logic [RCW-1:0]       res_after_pop;
  logic [RCW-1:0]       res_count_nxt;
  logic                 res_full;
  logic                 res_req;
  logic                 res_push;
  logic                 res_pop;
  logic                 ovf_inc;

  // Registered outputs
  logic                 empty_q;
  entry_t               head_q;
  logic [15:0]          ovf_q;
  logic                 tag_err_q;

  // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
  always_comb begin
    tag_empty     = (tag_count == '0);
    tag_full      = (tag_count == TAG_FULL);
    tag_pop       = bus.rx_hash_valid && !tag_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    tag_push      = bus.rx_key_valid && (!tag_full || tag_pop);

    tag_err_set   = (bus.rx_key_valid  && tag_full && !tag_pop)
                 || (bus.rx_hash_valid && tag_empty)
                 || (bus.rx_cmp_valid  && !pend_valid)
                 || (bus.rx_hash_valid && pend_valid && !bus.rx_cmp_valid);

    res_req       = bus.rx_cmp_valid && bus.rx_cmp_match && pend_valid;
    res_pop       = bus.rd_en && (res_count != '0);
    res_full      = (res_count == RES_FULL);
    res_push      = res_req && (!res_full || res_pop);
    ovf_inc       = res_req && res_full && !res_pop;

    res_after_pop = res_count - RCW'(res_pop);
    res_count_nxt = res_after_pop + RCW'(res_push);
  end

  // NOTE: storage arrays carry no reset; occupancy counters alone decide which words are meaningful.
  always_ff @(posedge mining_clk) begin
    if (tag_push) tag_mem[tag_wr_ptr] <= bus.rx_key_cnt;
    if (res_push) res_mem[res_wr_ptr] <= pend;
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge mining_clk) begin
    if (reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
      pend_valid <= 1'b0;
      pend       <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_count  <= '0;
      empty_q    <= 1'b1;
      head_q     <= '0;
      ovf_q      <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + TPW'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TPW'(1);
      tag_count <= tag_count + TCW'(tag_push) - TCW'(tag_pop);

      // The compare consumes the old pending before a same-cycle hash reloads it.
      if (bus.rx_hash_valid) begin
        pend_valid <= 1'b1;
        pend.cnt   <= tag_empty ? '1 : tag_mem[tag_rd_ptr];
        pend.hash  <= bus.rx_hash;
      end else if (bus.rx_cmp_valid) begin
        pend_valid <= 1'b0;
      end

      if (res_push) res_wr_ptr <= res_wr_ptr + RPW'(1);
      if (res_pop)  res_rd_ptr <= res_rd_ptr + RPW'(1);
      res_count <= res_count_nxt;
      empty_q   <= (res_count_nxt == '0);

      // Head register tracks what the FIFO head will be after this edge; holds when drained.
      if (res_push && res_after_pop == '0) begin
        head_q <= pend;
      end else if (res_pop && res_after_pop != '0) begin
        head_q <= res_mem[res_rd_ptr + RPW'(1)];
      end

      if (ovf_inc && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      if (tag_err_set) tag_err_q <= 1'b1;
    end
  end

  assign bus.tx_empty     = empty_q;
  assign bus.tx_count     = res_count;
  assign bus.tx_cnt       = head_q.cnt;
  assign bus.tx_hash      = head_q.hash;
  assign bus.tx_overflow  = ovf_q;
  assign bus.tx_tag_error = tag_err_q;

endmodule
